// File: rtl/ram2x8_fifo_ctrl.sv
// Byte FIFO controller wrapped around the single-port 2-word ram2x8.
// Two bytes live in the RAM and a third sits in the registered output stage.
module ram2x8_fifo_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [1:0]        count,
  output logic              mem_address,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ram_state_t;

  ram_state_t ram_cnt;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] ram_cnt_bits;
  logic       pop;
  logic       fetch;
  logic       push;
  logic       write_offered;

  // Refilling the output register always takes the single RAM port first.
  assign pop           = rd_valid & rd_ready;
  assign fetch         = !clear && (ram_cnt != EMPTY) && (!rd_valid || pop);
  assign write_offered = !clear && !fetch && (ram_cnt != FULL);
  assign wr_ready      = write_offered;
  assign push          = wr_valid & write_offered;

  assign mem_rw    = push;
  assign mem_wdata = wr_data;

  always_comb begin
    mem_address = 1'b0;
    if (clear)
      mem_address = 1'b0;
    else if (write_offered)
      mem_address = wr_ptr;
    else
      mem_address = rd_ptr;
  end

  assign ram_cnt_bits = ram_cnt;
  assign count        = ram_cnt_bits + {1'b0, rd_valid};

  always_ff @(posedge clock) begin
    if (clear) begin
      ram_cnt  <= EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (fetch) begin
      rd_data  <= mem_rdata;
      rd_valid <= 1'b1;
      rd_ptr   <= ~rd_ptr;
      case (ram_cnt)
        FULL:    ram_cnt <= ONE;
        default: ram_cnt <= EMPTY;
      endcase
    end else begin
      if (pop)
        rd_valid <= 1'b0;
      if (push) begin
        wr_ptr <= ~wr_ptr;
        case (ram_cnt)
          EMPTY:   ram_cnt <= ONE;
          default: ram_cnt <= FULL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram2x8_fifo_ctrl.sv
// Directed bench for ram2x8_fifo_ctrl with a behavioural ram2x8 attached.
// Inputs change just after each falling edge; outputs are sampled 1 time unit later.
module tb_ram2x8_fifo_ctrl;

  logic       clock = 1'b0;
  logic       clear;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [1:0] count;
  logic       mem_address;
  logic       mem_rw;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // ram2x8 model: combinational read, write on the rising edge when rw=1.
  assign mem_rdata = ram[mem_address];
  always @(posedge clock)
    if (mem_rw) ram[mem_address] <= mem_wdata;

  ram2x8_fifo_ctrl #(.DATA_W(8)) dut (
    .clock       (clock),
    .clear       (clear),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .mem_address (mem_address),
    .mem_rw      (mem_rw),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  task automatic apply_stimulus(input logic clr, input logic wv, input logic [7:0] wd,
                                input logic rr);
    @(negedge clock);
    clear    = clr;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    ram[0]   = 8'h00;
    ram[1]   = 8'h00;
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    rd_ready = 1'b0;

    // Reset held two cycles with a producer already asserting valid
    apply_stimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    check_output("rst_wr_ready", wr_ready, 8'h00);
    check_output("rst_mem_rw", mem_rw, 8'h00);
    check_output("rst_mem_addr", mem_address, 8'h00);
    check_output("rst_rd_valid", rd_valid, 8'h00);
    check_output("rst_count", count, 8'h00);
    check_output("rst_rd_data", rd_data, 8'h00);
    apply_stimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    check_output("rst2_wr_ready", wr_ready, 8'h00);
    check_output("rst2_mem_rw", mem_rw, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("rel_wr_ready", wr_ready, 8'h01);
    check_output("rel_count", count, 8'h00);

    // Single byte through an empty FIFO
    apply_stimulus(1'b0, 1'b1, 8'hA5, 1'b0);
    check_output("sb_c0_mem_rw", mem_rw, 8'h01);
    check_output("sb_c0_addr", mem_address, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("sb_c1_mem_rw", mem_rw, 8'h00);
    check_output("sb_c1_addr", mem_address, 8'h00);
    check_output("sb_c1_rd_valid", rd_valid, 8'h00);
    check_output("sb_c1_wr_ready", wr_ready, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("sb_c2_rd_valid", rd_valid, 8'h01);
    check_output("sb_c2_rd_data", rd_data, 8'hA5);
    check_output("sb_c2_count", count, 8'h01);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("sb_pop_rd_valid", rd_valid, 8'h00);
    check_output("sb_pop_rd_data_hold", rd_data, 8'hA5);
    check_output("sb_pop_count", count, 8'h00);

    // Fill: both pointers now sit at 1
    apply_stimulus(1'b0, 1'b1, 8'h11, 1'b0);
    check_output("fill_11_accept", wr_ready, 8'h01);
    check_output("fill_11_addr", mem_address, 8'h01);
    apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0);
    check_output("fill_22_blocked", wr_ready, 8'h00);
    check_output("fill_22_blocked_rw", mem_rw, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0);
    check_output("fill_22_accept", wr_ready, 8'h01);
    check_output("fill_22_count", count, 8'h01);
    apply_stimulus(1'b0, 1'b1, 8'h33, 1'b0);
    check_output("fill_33_accept", wr_ready, 8'h01);
    check_output("fill_33_count", count, 8'h02);
    apply_stimulus(1'b0, 1'b1, 8'h44, 1'b0);
    check_output("fill_full_wr_ready", wr_ready, 8'h00);
    check_output("fill_full_mem_rw", mem_rw, 8'h00);
    check_output("fill_full_count", count, 8'h03);
    check_output("fill_head", rd_data, 8'h11);
    apply_stimulus(1'b0, 1'b1, 8'h44, 1'b0);
    check_output("fill_hold_wr_ready", wr_ready, 8'h00);
    check_output("fill_hold_count", count, 8'h03);
    check_output("fill_hold_rd_data", rd_data, 8'h11);

    // Drain while still offering 44 then 55
    apply_stimulus(1'b0, 1'b1, 8'h44, 1'b1);
    check_output("dr0_rd_data", rd_data, 8'h11);
    check_output("dr0_wr_ready", wr_ready, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h44, 1'b1);
    check_output("dr1_rd_data", rd_data, 8'h22);
    check_output("dr1_rd_valid", rd_valid, 8'h01);
    apply_stimulus(1'b0, 1'b1, 8'h44, 1'b1);
    check_output("dr2_rd_data", rd_data, 8'h33);
    check_output("dr2_wr_ready", wr_ready, 8'h01);
    check_output("dr2_addr", mem_address, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h55, 1'b1);
    check_output("dr3_rd_valid", rd_valid, 8'h00);
    check_output("dr3_wr_ready", wr_ready, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h55, 1'b1);
    check_output("dr4_rd_data", rd_data, 8'h44);
    check_output("dr4_rd_valid", rd_valid, 8'h01);
    check_output("dr4_wr_ready", wr_ready, 8'h01);
    check_output("dr4_addr", mem_address, 8'h01);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check_output("dr5_rd_valid", rd_valid, 8'h00);
    check_output("dr5_fetch_addr", mem_address, 8'h01);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check_output("dr6_rd_data", rd_data, 8'h55);
    check_output("dr6_rd_valid", rd_valid, 8'h01);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check_output("dr7_rd_valid", rd_valid, 8'h00);
    check_output("dr7_count", count, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("empty_ignore_rd_valid", rd_valid, 8'h00);
    check_output("empty_ignore_count", count, 8'h00);

    // Contention: one byte in RAM, one in the output register, pop + write together
    apply_stimulus(1'b0, 1'b1, 8'h66, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h77, 1'b0);
    check_output("ct_setup_head", rd_data, 8'h66);
    check_output("ct_setup_accept", wr_ready, 8'h01);
    apply_stimulus(1'b0, 1'b1, 8'h88, 1'b1);
    check_output("ct_wr_ready", wr_ready, 8'h00);
    check_output("ct_mem_rw", mem_rw, 8'h00);
    check_output("ct_addr", mem_address, 8'h01);
    check_output("ct_count", count, 8'h02);
    apply_stimulus(1'b0, 1'b1, 8'h88, 1'b0);
    check_output("ct_next_rd_data", rd_data, 8'h77);
    check_output("ct_next_wr_ready", wr_ready, 8'h01);
    check_output("ct_next_mem_rw", mem_rw, 8'h01);
    check_output("ct_next_addr", mem_address, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h99, 1'b0);
    check_output("ct_99_count", count, 8'h02);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("pre_clear_count", count, 8'h03);

    // Clear with the FIFO full, then a fresh byte
    apply_stimulus(1'b1, 1'b1, 8'h12, 1'b0);
    check_output("clr_wr_ready", wr_ready, 8'h00);
    check_output("clr_mem_rw", mem_rw, 8'h00);
    check_output("clr_addr", mem_address, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h5A, 1'b0);
    check_output("postclr_count", count, 8'h00);
    check_output("postclr_rd_valid", rd_valid, 8'h00);
    check_output("postclr_wr_ready", wr_ready, 8'h01);
    check_output("postclr_addr", mem_address, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("postclr_c1_rd_valid", rd_valid, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("postclr_c2_rd_valid", rd_valid, 8'h01);
    check_output("postclr_c2_rd_data", rd_data, 8'h5A);
    check_output("postclr_c2_count", count, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram2x8_fifo_ctrl.md
Name: ram2x8_fifo_ctrl

Overview:
- Controller placed directly upstream of ram2x8. It turns the 2-word, single-port RAM into a 2+1 entry byte FIFO with valid/ready handshakes on both sides.
- Drives the RAM's address, rw and write-data inputs, and consumes its 8-bit read data into an output holding register.
- Total capacity is 3 bytes: 2 words in RAM plus 1 in the output register.

Parameters:
- DATA_W, 8, data width; fixed at 8 to match ram2x8. Any other value is unsupported.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- clear  in  1  reset, synchronous, active-high
- wr_data  in  8  byte to enqueue
- wr_valid  in  1  producer has a byte on wr_data
- wr_ready  out  1  controller accepts wr_data this cycle (combinational)
- rd_data  out  8  head byte (registered)
- rd_valid  out  1  rd_data holds a valid byte (registered)
- rd_ready  in  1  consumer takes rd_data this cycle
- count  out  2  total occupancy 0..3 (RAM words + output register)
- mem_address  out  1  to ram2x8 address (combinational)
- mem_rw  out  1  to ram2x8 rw: 1 = write, 0 = read (combinational)
- mem_wdata  out  8  to ram2x8 i1..i8; equals wr_data
- mem_rdata  in  8  from ram2x8 o1..o8; combinational read of mem_address

Behaviour:
- Reset: clear=1 at a rising edge sets the following, all updated in that same edge:
  - wr_ptr=0, rd_ptr=0, ram_cnt=0 (state EMPTY)
  - rd_valid=0, rd_data=8'h00, count=0
- While clear=1: wr_ready=0, mem_rw=0, mem_address=0.
- The RAM occupancy FSM tracks ram_cnt with states EMPTY(0), ONE(1), FULL(2).
- pop = rd_valid & rd_ready.
- RAM is single-port, so at most one RAM operation per cycle. Arbitration each cycle:
  1. fetch = (ram_cnt!=0) & (!rd_valid | pop). Then mem_address=rd_ptr, mem_rw=0, wr_ready=0. At the edge: rd_data<=mem_rdata, rd_valid<=1, rd_ptr toggles, ram_cnt decrements.
  2. Otherwise, write is offered with wr_ready = (ram_cnt!=2). Then mem_address=wr_ptr and mem_rw=wr_valid&wr_ready. On acceptance at the edge, wr_ptr toggles and ram_cnt increments.
  3. Otherwise idle: mem_rw=0, mem_address=rd_ptr.
- Pop without fetch: rd_valid<=0 at the edge and rd_data holds its value.
- Pop with fetch: rd_valid stays 1 and rd_data takes the new byte, with no bubble.
- Pointers wrap 1->0 (1-bit toggle).
- count = ram_cnt + rd_valid, registered-consistent: it reflects post-edge state.
- Latency: a byte written at edge N into an empty FIFO is fetched in cycle N+1 and is visible as rd_valid=1 in cycle N+2.
- Ordering is strict FIFO. No byte is lost or duplicated.
- Full: ram_cnt=2 forces wr_ready=0 regardless of rd_valid.
- Empty: with ram_cnt=0 and rd_valid=0, rd_ready is ignored.
- Simultaneous write and pop when a fetch is required: fetch wins and wr_ready=0 for that cycle. The producer must hold wr_data and wr_valid until wr_ready=1.
- wr_valid while wr_ready=0 has no effect and mem_rw stays 0.
- rd_data stays stable while rd_valid=1 and rd_ready=0.
- clear mid-operation: all contents are discarded on the next edge. RAM contents are not erased but become unreachable.

Test Plan:
- Reset: clear=1 for 2 cycles with wr_valid=1 -> wr_ready=0, mem_rw=0, rd_valid=0, count=0, rd_data=8'h00. Cycle after release: wr_ready=1.
- Single byte: write 8'hA5 at cycle 0, rd_ready=0 -> cycle 0 mem_rw=1, mem_address=0. Cycle 1 mem_rw=0, mem_address=0. Cycle 2 rd_valid=1, rd_data=8'hA5, count=1.
- Fill: offer 8'h11, 8'h22, 8'h33, 8'h44 back-to-back, rd_ready=0 -> rd_data=8'h11, count reaches 3, wr_ready=0, 8'h44 held unaccepted.
- Drain and wrap: from the fill state set rd_ready=1 and keep offering 8'h44, 8'h55 -> output sequence 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with no duplicates. wr_ptr and rd_ptr each wrap 1->0 at least once.
- Contention: ram_cnt=1, rd_valid=1, pop and wr_valid in the same cycle -> that cycle wr_ready=0, mem_rw=0. Next rd_data is the RAM byte. The write is accepted the following cycle.
- Clear mid-stream: count=3, then clear=1 for 1 cycle -> next cycle count=0, rd_valid=0, wr_ready=1. A new byte 8'h5A emerges first at rd_data 2 cycles after it is written.
